// File: rtl/command_stream_encoder_pkg.sv
// Shared rasterizer command definitions: opcode layout, texture size encodings,
// encoder state type and helpers for header packing and payload word counts.
package command_stream_encoder_pkg;

    localparam int OP_SIZE     = 4;
    localparam int OP_IMM_SIZE = 24;
    localparam int OP_POS      = 28;

    typedef enum logic [OP_SIZE-1:0] {
        NOP_STREAM      = 4'd0,
        TRIANGLE_STREAM = 4'd1,
        TEXTURE_STREAM  = 4'd2,
        RENDER_CONFIG   = 4'd3,
        FRAMEBUFFER     = 4'd4
    } op_e;

    localparam int TEXTURE_STREAM_SIZE_POS  = 0;
    localparam int TEXTURE_STREAM_SIZE_SIZE = 4;
    localparam int TEXTURE_STREAM_MODE_POS  = 4;

    localparam logic [TEXTURE_STREAM_SIZE_SIZE-1:0] TEX_SIZE_32  = 4'd1;
    localparam logic [TEXTURE_STREAM_SIZE_SIZE-1:0] TEX_SIZE_64  = 4'd2;
    localparam logic [TEXTURE_STREAM_SIZE_SIZE-1:0] TEX_SIZE_128 = 4'd3;
    localparam logic [TEXTURE_STREAM_SIZE_SIZE-1:0] TEX_SIZE_256 = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PAD     = 3'd3,
        ST_DRAIN   = 3'd4
    } enc_state_e;

    function automatic logic [31:0] build_header(input logic [OP_SIZE-1:0]     op,
                                                 input logic [OP_IMM_SIZE-1:0] imm);
        logic [31:0] hdr;
        hdr = 32'd0;
        hdr[OP_POS +: OP_SIZE] = op;
        hdr[OP_IMM_SIZE-1:0]   = imm;
        return hdr;
    endfunction

    // Texture sizes are in bytes (size*size*2) before division by the bus byte width.
    function automatic logic [31:0] payload_words(input logic [OP_SIZE-1:0]     op,
                                                  input logic [OP_IMM_SIZE-1:0] imm,
                                                  input int unsigned            bus_width);
        logic [31:0]                         words;
        logic [31:0]                         imm_ext;
        logic [TEXTURE_STREAM_SIZE_SIZE-1:0] size_code;
        logic [31:0]                         shift;
        shift     = (bus_width == 32'd16) ? 32'd1 : 32'd2;
        imm_ext   = {{(32-OP_IMM_SIZE){1'b0}}, imm};
        size_code = imm[TEXTURE_STREAM_SIZE_POS +: TEXTURE_STREAM_SIZE_SIZE];
        case (op)
            TRIANGLE_STREAM: words = imm_ext >> shift;
            TEXTURE_STREAM: begin
                case (size_code)
                    TEX_SIZE_32:  words = 32'd2048   >> shift;
                    TEX_SIZE_64:  words = 32'd8192   >> shift;
                    TEX_SIZE_128: words = 32'd32768  >> shift;
                    TEX_SIZE_256: words = 32'd131072 >> shift;
                    default:      words = 32'd0;
                endcase
            end
            RENDER_CONFIG:   words = 32'd1;
            default:         words = 32'd0;
        endcase
        return words;
    endfunction

endpackage

// File: rtl/command_stream_encoder_skid.sv
// One-entry registered AXI-Stream stage; accepts a new word whenever empty or
// while the held word is being taken downstream.
module axis_skid_register #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata
);

    logic                  valid_r;
    logic                  last_r;
    logic [DATA_WIDTH-1:0] data_r;

    assign s_axis_tready = !valid_r || m_axis_tready;
    assign m_axis_tvalid = valid_r;
    assign m_axis_tlast  = last_r;
    assign m_axis_tdata  = data_r;

    // Output holding register; contents only change when empty or being accepted.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            data_r  <= '0;
        end else if (s_axis_tready) begin
            valid_r <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                last_r <= s_axis_tlast;
                data_r <= s_axis_tdata;
            end
        end
    end

endmodule

// File: rtl/command_stream_encoder.sv
// Turns high-level requests into a header word plus an exactly sized payload,
// padding short payloads and dropping excess words.
module command_stream_encoder
    import command_stream_encoder_pkg::*;
#(
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int COUNTER_WIDTH    = 17
) (
    input  logic                        aclk,
    input  logic                        resetn,
    input  logic                        s_req_valid,
    output logic                        s_req_ready,
    input  logic [OP_SIZE-1:0]          s_req_op,
    input  logic [OP_IMM_SIZE-1:0]      s_req_imm,
    input  logic                        s_payload_axis_tvalid,
    output logic                        s_payload_axis_tready,
    input  logic                        s_payload_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0] s_payload_axis_tdata,
    output logic                        m_cmd_axis_tvalid,
    input  logic                        m_cmd_axis_tready,
    output logic                        m_cmd_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
    output logic                        errPayloadShort,
    output logic                        errPayloadLong,
    input  logic                        errClear,
    output logic                        busy
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    enc_state_e                  state_r, state_s;
    logic [COUNTER_WIDTH-1:0]    cnt_r, cnt_s;
    logic                        long_r, long_s;
    logic                        err_short_r, err_long_r;
    logic                        set_short_s, set_long_s;
    logic [COUNTER_WIDTH-1:0]    req_words_s;
    logic [CMD_STREAM_WIDTH-1:0] header_s;
    logic                        skid_valid_s, skid_ready_s, skid_last_s;
    logic [CMD_STREAM_WIDTH-1:0] skid_data_s;
    logic                        payload_ready_s;
    logic                        out_fire_s;

    assign req_words_s = COUNTER_WIDTH'(payload_words(s_req_op, s_req_imm, CMD_STREAM_WIDTH));
    assign header_s    = CMD_STREAM_WIDTH'(build_header(s_req_op, s_req_imm));
    assign out_fire_s  = m_cmd_axis_tvalid && m_cmd_axis_tready;

    assign s_req_ready           = (state_r == ST_IDLE);
    assign busy                  = (state_r != ST_IDLE);
    assign s_payload_axis_tready = payload_ready_s;
    assign errPayloadShort       = err_short_r;
    assign errPayloadLong        = err_long_r;

    axis_skid_register #(.DATA_WIDTH(CMD_STREAM_WIDTH)) u_out_reg (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_axis_tvalid (skid_valid_s),
        .s_axis_tready (skid_ready_s),
        .s_axis_tlast  (skid_last_s),
        .s_axis_tdata  (skid_data_s),
        .m_axis_tvalid (m_cmd_axis_tvalid),
        .m_axis_tready (m_cmd_axis_tready),
        .m_axis_tlast  (m_cmd_axis_tlast),
        .m_axis_tdata  (m_cmd_axis_tdata)
    );

    // Next-state, word counter and output-stage push decisions.
    always_comb begin
        state_s         = state_r;
        cnt_s           = cnt_r;
        long_s          = long_r;
        skid_valid_s    = 1'b0;
        skid_last_s     = 1'b0;
        skid_data_s     = '0;
        payload_ready_s = 1'b0;
        set_short_s     = 1'b0;
        set_long_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (s_req_valid) begin
                    skid_valid_s = 1'b1;
                    skid_data_s  = header_s;
                    skid_last_s  = (req_words_s == CNT_ZERO);
                    cnt_s        = req_words_s;
                    long_s       = 1'b0;
                    state_s      = ST_HEADER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (out_fire_s) begin
                    state_s = (cnt_r != CNT_ZERO) ? ST_PAYLOAD : ST_IDLE;
                end else begin
                    state_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (cnt_r != CNT_ZERO) begin
                    payload_ready_s = skid_ready_s;
                    skid_valid_s    = s_payload_axis_tvalid && skid_ready_s;
                    skid_data_s     = s_payload_axis_tdata;
                    skid_last_s     = (cnt_r == CNT_ONE);
                    if (skid_valid_s) begin
                        cnt_s = cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            set_long_s = !s_payload_axis_tlast;
                            long_s     = !s_payload_axis_tlast;
                        end else if (s_payload_axis_tlast) begin
                            set_short_s = 1'b1;
                            state_s     = ST_PAD;
                        end else begin
                            state_s = ST_PAYLOAD;
                        end
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else if (out_fire_s) begin
                    // Counter exhausted: leave once the final word is taken downstream.
                    state_s = long_r ? ST_DRAIN : ST_IDLE;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_PAD: begin
                if (cnt_r != CNT_ZERO) begin
                    skid_valid_s = skid_ready_s;
                    skid_last_s  = (cnt_r == CNT_ONE);
                    if (skid_valid_s) begin
                        cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else if (out_fire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PAD;
                end
            end
            ST_DRAIN: begin
                payload_ready_s = 1'b1;
                if (s_payload_axis_tvalid && s_payload_axis_tlast) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and sticky error registers; a set beats a same-cycle clear.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            long_r      <= 1'b0;
            err_short_r <= 1'b0;
            err_long_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            long_r      <= long_s;
            err_short_r <= set_short_s || (err_short_r && !errClear);
            err_long_r  <= set_long_s  || (err_long_r  && !errClear);
        end
    end

endmodule

// File: doc/command_stream_encoder.md
Name: command_stream_encoder

Overview:
- Builds the AXI-Stream command stream consumed by the rasterizer command parser, so a host-side or DMA-side producer can issue high-level requests instead of hand-packed words.
- Per accepted request: emits one header word (opcode + immediate), then forwards the exact number of payload words the parser expects for that opcode.
- Enforces payload length: pads a short payload with zero words, drops any excess, and reports both cases through sticky error flags.

Parameters:
CMD_STREAM_WIDTH, 32, width of the command and payload streams; must be 16 or 32.
COUNTER_WIDTH, 17, payload word counter width; covers a 256x256 texture at 16 bit (65536 words).

Ports:
aclk  in  1  clock
resetn  in  1  reset; synchronous, active-low
s_req_valid  in  1  request valid
s_req_ready  out  1  request accepted when valid & ready
s_req_op  in  OP_SIZE  opcode, from shared package
s_req_imm  in  OP_IMM_SIZE  immediate field
s_payload_axis_tvalid  in  1  payload valid
s_payload_axis_tready  out  1  payload ready
s_payload_axis_tlast  in  1  last payload word of this request
s_payload_axis_tdata  in  CMD_STREAM_WIDTH  payload data
m_cmd_axis_tvalid  out  1  command word valid
m_cmd_axis_tready  in  1  downstream ready
m_cmd_axis_tlast  out  1  last word of the current command
m_cmd_axis_tdata  out  CMD_STREAM_WIDTH  command word
errPayloadShort  out  1  sticky: payload tlast arrived before the expected count
errPayloadLong  out  1  sticky: payload continued past the expected count
errClear  in  1  clears both error flags
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; s_req_ready=1; s_payload_axis_tready=0; m_cmd_axis_tvalid=0, tlast=0, tdata=0; both error flags 0; busy=0. A reset mid-command abandons it; no partial words are emitted afterwards.
- Output is registered. Once m_cmd_axis_tvalid is asserted, tdata and tlast are held until tready. No combinational path from m_cmd_axis_tready to m_cmd_axis_tvalid.
- Payload words needed, N, by opcode:
  - TRIANGLE_STREAM: imm >> log2(CMD_STREAM_WIDTH/8). Low byte-offset bits are ignored.
  - TEXTURE_STREAM: size field 32/64/128/256 gives size*size*2/(CMD_STREAM_WIDTH/8). Size field 0 gives N=0.
  - RENDER_CONFIG: N=1.
  - FRAMEBUFFER and NOP_STREAM: N=0.
- States:
  - IDLE: s_req_ready=1. On handshake at cycle T: latch op, imm and N; go to HEADER; s_req_ready=0 at T+1.
  - HEADER: drive header {op at OP_POS, imm, zero elsewhere}, valid at T+1. tlast=1 iff N=0. On output handshake: go to PAYLOAD if N>0, else IDLE.
  - PAYLOAD:
    - s_payload_axis_tready = output register empty or being accepted this cycle (single-entry skid). Steady state is 1 word/cycle.
    - Each accepted word is forwarded and the counter decrements. The word where the counter reaches 1 carries m_cmd_axis_tlast=1.
    - Payload tlast with counter>1: set errPayloadShort; go to PAD.
    - Counter reaches 1 without payload tlast: set errPayloadLong; go to DRAIN after the last word is forwarded.
    - Otherwise return to IDLE after the final output handshake.
  - PAD: emit zero words until the counter is exhausted; the final zero word carries tlast; then IDLE. Payload tready=0.
  - DRAIN: payload tready=1; words are dropped with no output. On payload tlast go to IDLE.
- errClear on the same cycle as a set event: set wins.
- busy=1 in every state except IDLE.
- Only one request is in flight; the next header never overlaps the previous command.

Decomposition:
- Shared package (existing register/descriptor defines): OP_POS, OP_SIZE, OP_IMM_SIZE, opcodes, TEXTURE_STREAM_SIZE_POS/MODE_POS, texture size encodings.
- New in the same package: a word-count function (op, imm, bus width), shared by this block and its testbench.
- One sub-module: axis_skid_register (a one-entry registered AXIS stage holding tdata/tlast).

Test Plan:
- CMD_STREAM_WIDTH=32, TRIANGLE_STREAM imm=24, 6 payload words with tlast on word 6 -> header + 6 words, tlast on word 6, no errors.
- TEXTURE_STREAM size=32x32, payload 512 words, m_cmd_axis_tready toggled 1/0 each cycle -> 513 words out in order, data held stable while stalled, tlast on word 513.
- RENDER_CONFIG imm=2, one payload word 0x0000BEEF -> header, then 0x0000BEEF with tlast.
- FRAMEBUFFER request -> a single header word with tlast=1; payload tready stays 0 throughout.
- TRIANGLE_STREAM imm=16 (4 words), payload tlast on word 2 -> 2 data words + 2 zero words, tlast on the 4th; errPayloadShort=1.
- TRIANGLE_STREAM imm=8 (2 words), payload of 5 words -> 2 forwarded, 3 dropped; errPayloadLong=1; next request accepted only after the dropped tlast.
- Reset asserted mid-texture payload -> all outputs at reset values next cycle; a following NOP request emits one clean header word.
